div16seq: RTL and testbench



---
 rtl/div16seq.sv | 179 +++++++++++++++++
 tb/tb_div16seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div16seq.sv
// ---------------------------------------------------------------------------
// div16seq -- sequential 16-bit shift-and-subtract divider (one bit/cycle)
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   start       in   request pulse, accepted only while idle
//   dividend    in   [15:0] numerator, sampled on the accepting edge
//   divisor     in   [15:0] denominator, sampled on the accepting edge
//   busy        out  high while iterating
//   done        out  one-cycle pulse, results valid
//   quotient    out  [15:0] result, held until overwritten by a later result
//   remainder   out  [15:0] result, held until overwritten by a later result
//   div_by_zero out  set with the result when the divisor was 0
//
// Build option: define DIV16_SIGNED_EN for two's-complement operands
// (magnitudes divided unsigned, signs restored on the final iteration).
// ---------------------------------------------------------------------------
module div16seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] r_q, r_d;          // partial remainder
  logic [15:0] q_q, q_d;          // dividend shifting out / quotient shifting in
  logic [15:0] d_q, d_d;          // latched divisor (magnitude)
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] quot_q, quot_d;
  logic [15:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;

  // Trial subtract {R,Q[15]} - D done as add-with-inverse; bit 17 is the
  // carry out, which is 1 when no borrow occurs. The full 17-bit shifted
  // remainder is kept so divisors above 16'h8000 stay exact.
  logic [17:0] trial;
  logic        no_borrow;
  logic [15:0] r_next, q_next;

`ifdef DIV16_SIGNED_EN
  logic neg_q_q, neg_q_d;         // quotient sign: operand signs differ
  logic neg_r_q, neg_r_d;         // remainder sign: dividend negative

  function automatic logic [15:0] twos(input logic [15:0] x);
    return ~x + 16'd1;
  endfunction
`endif

  always_comb begin
    trial     = {1'b0, r_q, q_q[15]} + {2'b01, ~d_q} + 18'd1;
    no_borrow = trial[17];
    if (no_borrow) begin
      r_next = trial[15:0];
      q_next = {q_q[14:0], 1'b1};
    end else begin
      r_next = {r_q[14:0], q_q[15]};
      q_next = {q_q[14:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV16_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = FIN;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
            r_d     = '0;
            cnt_d   = '0;
`ifdef DIV16_SIGNED_EN
            q_d     = dividend[15] ? twos(dividend) : dividend;
            d_d     = divisor[15]  ? twos(divisor)  : divisor;
            neg_q_d = dividend[15] ^ divisor[15];
            neg_r_d = dividend[15];
`else
            q_d     = dividend;
            d_d     = divisor;
`endif
          end
        end
      end
      RUN: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = FIN;
          busy_d  = 1'b0;
`ifdef DIV16_SIGNED_EN
          quot_d  = neg_q_q ? twos(q_next) : q_next;
          rem_d   = neg_r_q ? twos(r_next) : r_next;
`else
          quot_d  = q_next;
          rem_d   = r_next;
`endif
        end
      end
      FIN: begin
        // done is registered, so it is high in the cycle after FIN.
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV16_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV16_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16seq.sv
// ---------------------------------------------------------------------------
// tb_div16seq -- directed self-checking bench for div16seq.
// Inputs change on the falling edge; outputs are sampled 1ns after the
// rising edge. Edge counts are relative to the accepting edge E.
// ---------------------------------------------------------------------------
module tb_div16seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int unsigned checks = 0;
  int unsigned passed = 0;

  div16seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one start pulse; returns just after the accepting edge E.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (bounded), and busy-high samples on the way.
  // The sample right after the caller's current edge counts as busy sample 0.
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = busy ? 1 : 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (busy) nbusy++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input int exp_n, input logic [15:0] eq, input logic [15:0] er,
                     input logic ez);
    int n, nb;
    issue(a, b);
    wait_done(n, nb);
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
  endtask

  initial begin
    int n, nb;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", quotient, 16'h0000);
    chk("rst_r", remainder, 16'h0000);
    chk("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 100/7: done at E+17, busy for 16 cycles, one-cycle done
    issue(16'd100, 16'd7);
    chk("u100_busyE", busy, 1'b1);
    wait_done(n, nb);
    chk("u100_lat", n, 17);
    chk("u100_busycyc", nb, 16);
    chk("u100_q", quotient, 16'h000E);
    chk("u100_r", remainder, 16'h0002);
    chk("u100_dbz", div_by_zero, 1'b0);
    @(posedge clk);
    #1;
    chk("u100_done_1cyc", done, 1'b0);

    // Full range
    run("ffff_1", 16'hFFFF, 16'h0001, 17, 16'hFFFF, 16'h0000, 1'b0);
`ifndef DIV16_SIGNED_EN
    run("3_ffff", 16'h0003, 16'hFFFF, 17, 16'h0000, 16'h0003, 1'b0);
    run("ffff_fffe", 16'hFFFF, 16'hFFFE, 17, 16'h0001, 16'h0001, 1'b0);
    run("u_fff9_2", 16'hFFF9, 16'h0002, 17, 16'h7FFC, 16'h0001, 1'b0);
`endif

    // Divide by zero, then a normal divide clears the flag
    issue(16'd5, 16'd0);
    chk("dbz_busyE", busy, 1'b0);
    wait_done(n, nb);
    chk("dbz_lat", n, 1);
    chk("dbz_q", quotient, 16'hFFFF);
    chk("dbz_r", remainder, 16'h0005);
    chk("dbz_flag", div_by_zero, 1'b1);
    run("9_3", 16'd9, 16'd3, 17, 16'h0003, 16'h0000, 1'b0);

    // Start while busy is ignored
    issue(16'd100, 16'd7);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, nb);
    chk("ign_lat", n, 12);
    chk("ign_q", quotient, 16'h000E);
    chk("ign_r", remainder, 16'h0002);
    // Start in the cycle right after done is accepted
    issue(16'd50, 16'd5);
    chk("after_done_busy", busy, 1'b1);
    wait_done(n, nb);
    chk("after_done_lat", n, 17);
    chk("after_done_q", quotient, 16'h000A);
    chk("after_done_r", remainder, 16'h0000);

    // Reset mid-operation at E+8
    issue(16'd100, 16'd7);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_q", quotient, 16'h0000);
    chk("midrst_r", remainder, 16'h0000);
    chk("midrst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    chk("midrst_nodone", n, 0);
    run("20_6", 16'd20, 16'd6, 17, 16'h0003, 16'h0002, 1'b0);

`ifdef DIV16_SIGNED_EN
    run("s_m7_2", 16'hFFF9, 16'h0002, 17, 16'hFFFD, 16'hFFFF, 1'b0);
    run("s_8000_m1", 16'h8000, 16'hFFFF, 17, 16'h8000, 16'h0000, 1'b0);
    run("s_3_m1", 16'h0003, 16'hFFFF, 17, 16'hFFFD, 16'h0000, 1'b0);
    run("s_dbz", 16'hFFF9, 16'h0000, 1, 16'hFFFF, 16'hFFF9, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
